// File: rtl/clint.sv
// rtl/clint.sv - core-local interrupt/exception sequencer (hold, CSR writes, redirect)
//
// Purpose:
//   Watches the execute-stage instruction for ecall/ebreak/mret and the
//   interrupt request lines. On an event it holds the whole pipeline. For a
//   trap it then writes mepc, mstatus and mcause over three cycles and
//   redirects to mtvec. For mret it writes mstatus once and redirects to mepc.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   int_flag_i          level interrupt requests (bit 0 = timer)
//   inst_i, inst_addr_i execute-stage instruction and its PC
//   jump_flag_i/addr_i  execute-stage redirect this cycle and its target
//   div_started_i       multi-cycle divide in flight (defers interrupts)
//   global_int_en_i     mstatus.MIE
//   csr_mtvec_i/mepc_i/mstatus_i  current CSR values
//   we_o, waddr_o, data_o         CSR write port (registered)
//   hold_flag_o         pipeline hold request
//   int_assert_o, int_addr_o      one-cycle redirect strobe and target (registered)

module clint #(
    parameter int          INT_NUM     = 8,
    parameter logic [31:0] CAUSE_TIMER = 32'h8000_0007,
    parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               div_started_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic               we_o,
    output logic [31:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               hold_flag_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_MRET
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] data_q, data_d;
    logic        int_assert_q, int_assert_d;
    logic [31:0] int_addr_q, int_addr_d;

    logic is_idle;
    logic ev_sync;
    logic ev_async;
    logic ev_mret;

    // Events are only decoded in IDLE; anything arriving mid-sequence is
    // ignored (interrupt lines are level and stay pending).
    assign is_idle  = (state_q == S_IDLE);
    assign ev_sync  = is_idle && ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK));
    assign ev_async = is_idle && !ev_sync && (|int_flag_i) && global_int_en_i && !div_started_i;
    assign ev_mret  = is_idle && !ev_sync && !ev_async && (inst_i == INST_MRET);

    assign hold_flag_o = ev_sync || ev_async || ev_mret || !is_idle;

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        we_d         = 1'b0;
        waddr_d      = 32'h0;
        data_d       = 32'h0;
        int_assert_d = 1'b0;
        int_addr_d   = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (ev_sync || ev_async) begin
                    state_d = S_MEPC;
                    if (ev_sync) begin
                        cause_d = (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
                        pc_d    = inst_addr_i;
                    end else begin
                        cause_d = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
                        // An interrupt taken while execute redirects must
                        // return to the redirect target, not the jump itself.
                        pc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
                    end
                    // mepc write is issued the cycle after detection, so it
                    // uses the freshly selected pc rather than pc_q.
                    we_d    = 1'b1;
                    waddr_d = CSR_MEPC;
                    data_d  = pc_d;
                end else if (ev_mret) begin
                    state_d      = S_MRET;
                    we_d         = 1'b1;
                    waddr_d      = CSR_MSTATUS;
                    // MIE <= MPIE, MPIE <= 1
                    data_d       = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                                    csr_mstatus_i[7], csr_mstatus_i[2:0]};
                    int_assert_d = 1'b1;
                    int_addr_d   = csr_mepc_i;
                end
            end
            S_MEPC: begin
                state_d = S_MSTATUS;
                we_d    = 1'b1;
                waddr_d = CSR_MSTATUS;
                // MPIE <= MIE, MIE <= 0
                data_d  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                           1'b0, csr_mstatus_i[2:0]};
            end
            S_MSTATUS: begin
                state_d      = S_MCAUSE;
                we_d         = 1'b1;
                waddr_d      = CSR_MCAUSE;
                data_d       = cause_q;
                int_assert_d = 1'b1;
                int_addr_d   = csr_mtvec_i;
            end
            S_MCAUSE: state_d = S_IDLE;
            S_MRET:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cause_q      <= 32'h0;
            pc_q         <= 32'h0;
            we_q         <= 1'b0;
            waddr_q      <= 32'h0;
            data_q       <= 32'h0;
            int_assert_q <= 1'b0;
            int_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            pc_q         <= pc_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
        end
    end

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign data_o       = data_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - directed self-checking bench for clint
module tb_clint;

    logic        clk;
    logic        rst;
    logic [7:0]  int_flag_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        div_started_i;
    logic        global_int_en_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] data_o;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    clint dut (
        .clk             (clk),
        .rst             (rst),
        .int_flag_i      (int_flag_i),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .div_started_i   (div_started_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .data_o          (data_o),
        .hold_flag_o     (hold_flag_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [31:0] waddr,
                              input logic [31:0] data, input logic hold,
                              input logic ia, input logic [31:0] iaddr);
        check({tag, ".we"},    {31'd0, we_o},         {31'd0, we});
        check({tag, ".waddr"}, waddr_o,               waddr);
        check({tag, ".data"},  data_o,                data);
        check({tag, ".hold"},  {31'd0, hold_flag_o},  {31'd0, hold});
        check({tag, ".ia"},    {31'd0, int_assert_o}, {31'd0, ia});
        check({tag, ".iaddr"}, int_addr_o,            iaddr);
    endtask

    // Advance to just after the next rising edge; inputs are changed here and
    // outputs are sampled one time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        int_flag_i = 8'h0; inst_i = NOP; inst_addr_i = 32'h0;
        jump_flag_i = 1'b0; jump_addr_i = 32'h0; div_started_i = 1'b0;
        global_int_en_i = 1'b1; csr_mtvec_i = 32'h80; csr_mepc_i = 32'h0;
        csr_mstatus_i = 32'h8;
        #12;
        check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b1;
        step();

        // ecall: hold at T, mepc/mstatus/mcause writes, redirect at T+3
        inst_i = 32'h0000_0073; inst_addr_i = 32'h100;
        #1 check_outs("ecall.T", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(); inst_i = NOP;
        #1 check_outs("ecall.T1", 1'b1, 32'h341, 32'h100, 1'b1, 1'b0, 32'h0);
        step();
        #1 check_outs("ecall.T2", 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
        step();
        #1 check_outs("ecall.T3", 1'b1, 32'h342, 32'd11, 1'b1, 1'b1, 32'h80);
        step();
        #1 check_outs("ecall.T4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // timer interrupt during a jump: mepc takes the jump target
        step();
        int_flag_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h200; inst_addr_i = 32'h1F0;
        #1 check("timer.T.hold", {31'd0, hold_flag_o}, 32'd1);
        step(); int_flag_i = 8'h0; jump_flag_i = 1'b0; global_int_en_i = 1'b0;
        #1 check_outs("timer.T1", 1'b1, 32'h341, 32'h200, 1'b1, 1'b0, 32'h0);
        step();
        #1 check_outs("timer.T2", 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
        step();
        #1 check_outs("timer.T3", 1'b1, 32'h342, 32'h8000_0007, 1'b1, 1'b1, 32'h80);
        step();
        #1 check("timer.T4.hold", {31'd0, hold_flag_o}, 32'd0);

        // external interrupt deferred while a divide is in flight
        global_int_en_i = 1'b1; int_flag_i = 8'h04; div_started_i = 1'b1; inst_addr_i = 32'h220;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("div.%0d.hold", i), {31'd0, hold_flag_o}, 32'd0);
            step();
        end
        div_started_i = 1'b0;
        #1 check("ext.T.hold", {31'd0, hold_flag_o}, 32'd1);
        step(); int_flag_i = 8'h0; global_int_en_i = 1'b0;
        #1 check_outs("ext.T1", 1'b1, 32'h341, 32'h220, 1'b1, 1'b0, 32'h0);
        step();
        step();
        #1 check_outs("ext.T3", 1'b1, 32'h342, 32'h8000_000B, 1'b1, 1'b1, 32'h80);
        step();

        // mret: single mstatus write and redirect to mepc at T+1
        inst_i = 32'h3020_0073; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80;
        #1 check("mret.T.hold", {31'd0, hold_flag_o}, 32'd1);
        step(); inst_i = NOP;
        #1 check_outs("mret.T1", 1'b1, 32'h300, 32'h88, 1'b1, 1'b1, 32'h104);
        step();
        #1 check_outs("mret.T2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // ebreak coincident with timer interrupt: exception wins
        csr_mstatus_i = 32'h8; global_int_en_i = 1'b1; int_flag_i = 8'h01;
        inst_i = 32'h0010_0073; inst_addr_i = 32'h300;
        #1 check("ebrk.T.hold", {31'd0, hold_flag_o}, 32'd1);
        step(); inst_i = NOP; global_int_en_i = 1'b0;
        #1 check_outs("ebrk.T1", 1'b1, 32'h341, 32'h300, 1'b1, 1'b0, 32'h0);
        step();
        #1 check_outs("ebrk.T2", 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
        step();
        #1 check_outs("ebrk.T3", 1'b1, 32'h342, 32'd3, 1'b1, 1'b1, 32'h80);
        step();
        #1 check_outs("ebrk.T4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        #1 check("ebrk.T5.hold", {31'd0, hold_flag_o}, 32'd0);
        int_flag_i = 8'h0;

        // reset asserted while the mstatus write is on the port
        step();
        global_int_en_i = 1'b1; inst_i = 32'h0000_0073; inst_addr_i = 32'h400;
        step(); inst_i = NOP;
        step();
        #1 check("rst.pre.waddr", waddr_o, 32'h300);
        #1 rst = 1'b0;
        #1 check_outs("rst.async", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b1;
        #1 check_outs("rst.after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        #1 check_outs("rst.idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        inst_i = 32'h0000_0073; inst_addr_i = 32'h500;
        step(); inst_i = NOP;
        #1 check_outs("rst.resume", 1'b1, 32'h341, 32'h500, 1'b1, 1'b0, 32'h0);
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
